// File: rtl/inst_rom_loader.sv
// Instruction memory for the MIPS32 core, filled from a byte stream before
// execution. Fetches are combinational; the core is held while loading.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  output logic              load_ready_o,
  input  logic              load_done_i,
  output logic              cpu_hold_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              load_err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  // Word count that means "memory full"; the pointer has one spare bit for it.
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [23:0]     hold_q, hold_d;
  logic            err_q, err_d;
  logic            byte_accept;
  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic            addr_in_range;
  logic            addr_lsb_unused;

  logic [31:0] mem [2**ADDR_W];

  assign load_ready_o   = (state_q == LOAD) && (ptr_q < DEPTH);
  assign cpu_hold_o     = (state_q != RUN);
  assign words_loaded_o = ptr_q;
  assign load_err_o     = err_q;
  assign byte_accept    = load_valid_i && load_ready_o;
  assign mem_wdata      = {hold_q, load_byte_i};

  // Byte-lane bits of the fetch address carry no information for word fetches.
  assign addr_lsb_unused = ^rom_addr_i[1:0];
  assign addr_in_range   = (rom_addr_i[31:ADDR_W+2] == '0);
  assign rom_data_o      = (rom_ce_i && (state_q == RUN) && addr_in_range)
                           ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;

  // Next-state logic: start wins over everything, then byte accept, then done.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (load_start_i) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD) begin
      if (byte_accept) begin
        if (cnt_q == 2'd3) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
          cnt_d  = '0;
        end else begin
          hold_d = {hold_q[15:0], load_byte_i};
          cnt_d  = cnt_q + 2'd1;
        end
      end
      if (load_done_i) begin
        if (cnt_d == 2'd0) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
    end
  end

  // Control registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared, so it has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q[ADDR_W-1:0]] <= mem_wdata;
    end
  end

endmodule
